// File: rtl/mac_link_pkg.sv
// mac_link_pkg: shared states, beat ordering and config byte layout for the MAC link driver.
package mac_link_pkg;

  typedef enum logic [2:0] {
    UNCFG  = 3'd0,
    CFG    = 3'd1,
    IDLE   = 3'd2,
    STREAM = 3'd3,
    WAIT   = 3'd4,
    CAP_HI = 3'd5,
    CAP_LO = 3'd6,
    HOLD   = 3'd7
  } state_e;

  localparam int NUM_BEATS    = 4;
  localparam int CFG_MODE_BIT = 7;
  localparam int CFG_ACT_W    = 7;

  // Bias byte index sent on each beat: beat0=byte1, beat1=byte0, beat2=byte3, beat3=byte2.
  localparam logic [NUM_BEATS-1:0][1:0] BEAT_BYTE = {2'd2, 2'd3, 2'd0, 2'd1};

  function automatic logic [7:0] bias_byte(input logic [31:0] bias, input logic [1:0] beat);
    return bias[{BEAT_BYTE[beat], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] cfg_byte(input logic mode, input logic [CFG_ACT_W-1:0] act);
    logic [7:0] b;
    b = '0;
    b[CFG_MODE_BIT] = mode;
    b[CFG_ACT_W-1:0] = act;
    return b;
  endfunction

endpackage

// File: rtl/mac_result_asm.sv
// mac_result_asm: captures the two returned result halves and holds the word until the host takes it.
module mac_result_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_hi,
  input  logic        cap_lo,
  input  logic [7:0]  mac_uo_i,
  input  logic [7:0]  mac_uio_i,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_fire
);

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [15:0] sample;

  assign sample = {mac_uo_i, mac_uio_i};
  assign res_fire = res_valid_q & res_ready;

  always_comb begin
    res_data_d  = cap_hi ? {sample, res_data_q[15:0]} : cap_lo ? {res_data_q[31:16], sample} : res_data_q;
    res_valid_d = cap_lo | (res_valid_q & ~res_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: rtl/mac_link_driver.sv
// mac_link_driver: configures the MAC, serializes weight/bias jobs into link beats, reassembles results.
// Define MAC_DRV_PERF_CNT_EN to add the saturating perf_jobs completed-result counter.
module mac_link_driver
  import mac_link_pkg::*;
#(
  parameter int CFG_CYCLES = 2,
  parameter int RES_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_mode,
  input  logic [6:0]  cfg_act,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [7:0]  job_weight,
  input  logic [31:0] job_bias,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        mac_rst_n,
  output logic [7:0]  mac_ui,
  output logic [7:0]  mac_uio_o,
  input  logic [7:0]  mac_uo_i,
  input  logic [7:0]  mac_uio_i
`ifdef MAC_DRV_PERF_CNT_EN
  ,
  output logic [15:0] perf_jobs
`endif
);

  localparam int CW = $clog2(CFG_CYCLES > NUM_BEATS + 8 ? CFG_CYCLES : NUM_BEATS + 8);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cfg_q, cfg_d;
  logic [7:0]    weight_q, weight_d;
  logic [31:0]   bias_q, bias_d;
  logic          cfg_fire, job_fire, res_fire;

  assign cfg_ready = state_q == UNCFG || state_q == IDLE;
  // Config has priority over a job offered in the same IDLE cycle.
  assign job_ready = state_q == IDLE && !cfg_valid;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign job_fire  = job_valid & job_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    cfg_d    = cfg_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    case (state_q)
      CFG:     if (cnt_q == CW'(CFG_CYCLES - 1)) state_d = IDLE;
      STREAM:  if (cnt_q == CW'(NUM_BEATS - 1)) begin
        state_d = RES_LAT == 0 ? CAP_HI : WAIT;
        cnt_d   = '0;
      end
      WAIT:    if (cnt_q == CW'(RES_LAT - 1)) state_d = CAP_HI;
      CAP_HI:  state_d = CAP_LO;
      CAP_LO:  state_d = HOLD;
      HOLD:    if (res_fire) state_d = IDLE;
      default: ;
    endcase
    if (cfg_fire) begin
      state_d = CFG;
      cnt_d   = '0;
      cfg_d   = cfg_byte(cfg_mode, cfg_act);
    end else if (job_fire) begin
      state_d  = STREAM;
      cnt_d    = '0;
      weight_d = job_weight;
      bias_d   = job_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= UNCFG;
      cnt_q    <= '0;
      cfg_q    <= '0;
      weight_q <= '0;
      bias_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
    end
  end

  assign mac_rst_n = !(state_q == UNCFG || state_q == CFG);
  assign mac_ui    = state_q == CFG ? cfg_q : state_q == STREAM ? weight_q : '0;
  assign mac_uio_o = state_q == STREAM ? bias_byte(bias_q, cnt_q[1:0]) : '0;

  mac_result_asm u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_hi    (state_q == CAP_HI),
    .cap_lo    (state_q == CAP_LO),
    .mac_uo_i  (mac_uo_i),
    .mac_uio_i (mac_uio_i),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_fire  (res_fire)
  );

`ifdef MAC_DRV_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;
  always_comb perf_d = cfg_fire ? '0 : (res_fire && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_jobs = perf_q;
`endif

endmodule
